// File: rtl/lsu_arbiter.sv
// Two-port arbiter in front of the MEM-stage LSU: port A (pipeline) has priority,
// port B (debug/loader) is force-granted after MAX_WAIT refusals; read data is routed back by owner.
module lsu_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_a,
    input  logic [31:0] i_addr_a,
    input  logic [31:0] i_wdata_a,
    input  logic [3:0]  i_bmask_a,
    input  logic        i_wren_a,
    input  logic        i_req_b,
    input  logic [31:0] i_addr_b,
    input  logic [31:0] i_wdata_b,
    input  logic [3:0]  i_bmask_b,
    input  logic        i_wren_b,
    output logic        o_gnt_a,
    output logic        o_gnt_b,
    output logic        o_stall_mem,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_lsu_wdata,
    output logic [3:0]  o_lsu_bmask,
    output logic        o_lsu_wren,
    input  logic [31:0] i_lsu_rdata,
    output logic        o_rvalid_a,
    output logic        o_rvalid_b,
    output logic [31:0] o_rdata
);

    typedef enum logic {A_PRIO, B_FORCE} state_t;

    localparam logic [8:0] MAX_W = 9'(MAX_WAIT);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt, wait_nxt;
    logic        gnt_a, gnt_b, gnt_any;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  bmask_q;
    logic        rd_push;
    logic [RD_LATENCY-1:0] vld_pipe, own_pipe;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= A_PRIO;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Grants are suppressed while reset is held so nothing reaches the LSU.
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            A_PRIO: begin
                if (i_req_a)      gnt_a = 1'b1;
                else if (i_req_b) gnt_b = 1'b1;
                if (i_req_b && !gnt_b) begin
                    wait_nxt = wait_cnt + 8'd1;
                    if ({1'b0, wait_cnt} + 9'd1 >= MAX_W) state_nxt = B_FORCE;
                end else begin
                    wait_nxt = 8'd0;
                end
            end
            B_FORCE: begin
                gnt_b     = i_req_b;
                state_nxt = A_PRIO;
                wait_nxt  = 8'd0;
            end
            default: begin
                state_nxt = A_PRIO;
                wait_nxt  = 8'd0;
            end
        endcase
        if (!i_reset) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    assign gnt_any     = gnt_a | gnt_b;
    assign o_gnt_a     = gnt_a;
    assign o_gnt_b     = gnt_b;
    assign o_stall_mem = i_reset & i_req_a & ~gnt_a;

    // Same-cycle mux on grant; otherwise hold the last issued address/data, never write.
    always_comb begin
        o_lsu_addr  = addr_q;
        o_lsu_wdata = wdata_q;
        o_lsu_bmask = bmask_q;
        o_lsu_wren  = 1'b0;
        if (gnt_a) begin
            o_lsu_addr  = i_addr_a;
            o_lsu_wdata = i_wdata_a;
            o_lsu_bmask = i_bmask_a;
            o_lsu_wren  = i_wren_a;
        end else if (gnt_b) begin
            o_lsu_addr  = i_addr_b;
            o_lsu_wdata = i_wdata_b;
            o_lsu_bmask = i_bmask_b;
            o_lsu_wren  = i_wren_b;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            bmask_q <= 4'd0;
        end else if (gnt_any) begin
            addr_q  <= o_lsu_addr;
            wdata_q <= o_lsu_wdata;
            bmask_q <= o_lsu_bmask;
        end
    end

    // Owner bit: 0 = port A, 1 = port B. The tail lines up with i_lsu_rdata.
    assign rd_push = gnt_any & ~o_lsu_wren;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            vld_pipe <= '0;
            own_pipe <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                own_pipe[i] <= own_pipe[i-1];
            end
            vld_pipe[0] <= rd_push;
            own_pipe[0] <= gnt_b;
        end
    end

    assign o_rvalid_a = vld_pipe[RD_LATENCY-1] & ~own_pipe[RD_LATENCY-1];
    assign o_rvalid_b = vld_pipe[RD_LATENCY-1] &  own_pipe[RD_LATENCY-1];
    assign o_rdata    = i_reset ? i_lsu_rdata : 32'd0;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed vector table, hand-written reset/withdraw sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_lsu_arbiter;

    localparam int RD_LATENCY = 1;
    localparam int MAX_WAIT   = 8;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_req_a = 1'b0, i_wren_a = 1'b0, i_req_b = 1'b0, i_wren_b = 1'b0;
    logic [31:0] i_addr_a = '0, i_wdata_a = '0, i_addr_b = '0, i_wdata_b = '0;
    logic [3:0]  i_bmask_a = '0, i_bmask_b = '0;
    logic [31:0] i_lsu_rdata = '0;
    logic        o_gnt_a, o_gnt_b, o_stall_mem, o_lsu_wren, o_rvalid_a, o_rvalid_b;
    logic [31:0] o_lsu_addr, o_lsu_wdata, o_rdata;
    logic [3:0]  o_lsu_bmask;

    lsu_arbiter #(.RD_LATENCY(RD_LATENCY), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req_a(i_req_a), .i_addr_a(i_addr_a), .i_wdata_a(i_wdata_a),
        .i_bmask_a(i_bmask_a), .i_wren_a(i_wren_a),
        .i_req_b(i_req_b), .i_addr_b(i_addr_b), .i_wdata_b(i_wdata_b),
        .i_bmask_b(i_bmask_b), .i_wren_b(i_wren_b),
        .o_gnt_a(o_gnt_a), .o_gnt_b(o_gnt_b), .o_stall_mem(o_stall_mem),
        .o_lsu_addr(o_lsu_addr), .o_lsu_wdata(o_lsu_wdata),
        .o_lsu_bmask(o_lsu_bmask), .o_lsu_wren(o_lsu_wren),
        .i_lsu_rdata(i_lsu_rdata), .o_rvalid_a(o_rvalid_a),
        .o_rvalid_b(o_rvalid_b), .o_rdata(o_rdata)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {int due; bit own_b;} rd_t;
    rd_t         rd_q[$];
    int          cyc;
    int          refusals;
    bit          forced;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_bmask;
    logic        obs_gnt_b;

    task automatic model_reset();
        rd_q.delete();
        refusals = 0;
        forced   = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_bmask  = '0;
    endtask

    // Inputs are already driven (at negedge); compare, then advance one clock.
    task automatic step(input string tag);
        bit ga, gb, rva, rvb, wr;
        logic [31:0] ad, wd;
        logic [3:0]  bm;
        #1;
        if (forced) begin ga = 0; gb = i_req_b; end
        else begin ga = i_req_a; gb = !i_req_a && i_req_b; end
        ad = m_addr; wd = m_wdata; bm = m_bmask; wr = 0;
        if (ga) begin ad = i_addr_a; wd = i_wdata_a; bm = i_bmask_a; wr = i_wren_a; end
        if (gb) begin ad = i_addr_b; wd = i_wdata_b; bm = i_bmask_b; wr = i_wren_b; end
        rva = 0; rvb = 0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            rva = !rd_q[0].own_b;
            rvb = rd_q[0].own_b;
        end
        chk({tag, ".gnt_a"}, o_gnt_a, ga);
        chk({tag, ".gnt_b"}, o_gnt_b, gb);
        chk({tag, ".stall"}, o_stall_mem, i_req_a && !ga);
        chk({tag, ".wren"}, o_lsu_wren, wr);
        chk({tag, ".addr"}, o_lsu_addr, ad);
        chk({tag, ".wdata"}, o_lsu_wdata, wd);
        chk({tag, ".bmask"}, o_lsu_bmask, bm);
        chk({tag, ".rvalid_a"}, o_rvalid_a, rva);
        chk({tag, ".rvalid_b"}, o_rvalid_b, rvb);
        chk({tag, ".rdata"}, o_rdata, i_lsu_rdata);
        obs_gnt_b = o_gnt_b;
        @(posedge i_clk);
        if (ga || gb) begin m_addr = ad; m_wdata = wd; m_bmask = bm; end
        if (rd_q.size() > 0 && rd_q[0].due == cyc) void'(rd_q.pop_front());
        if ((ga || gb) && !wr) rd_q.push_back('{cyc + RD_LATENCY, gb});
        if (forced) begin
            forced = 0; refusals = 0;
        end else if (i_req_b && !gb) begin
            refusals++;
            if (refusals >= MAX_WAIT) forced = 1;
        end else begin
            refusals = 0;
        end
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt_a"}, o_gnt_a, 0);
        chk({tag, ".gnt_b"}, o_gnt_b, 0);
        chk({tag, ".stall"}, o_stall_mem, 0);
        chk({tag, ".wren"}, o_lsu_wren, 0);
        chk({tag, ".addr"}, o_lsu_addr, 0);
        chk({tag, ".wdata"}, o_lsu_wdata, 0);
        chk({tag, ".bmask"}, o_lsu_bmask, 0);
        chk({tag, ".rvalid_a"}, o_rvalid_a, 0);
        chk({tag, ".rvalid_b"}, o_rvalid_b, 0);
        chk({tag, ".rdata"}, o_rdata, 0);
    endtask

    task automatic idle_inputs();
        i_req_a = 0; i_req_b = 0; i_wren_a = 0; i_wren_b = 0;
    endtask

    task automatic randomize_inputs();
        i_req_a = 1'($urandom); i_addr_a = $urandom; i_wdata_a = $urandom;
        i_bmask_a = 4'($urandom); i_wren_a = 1'($urandom);
        i_req_b = 1'($urandom); i_addr_b = $urandom; i_wdata_b = $urandom;
        i_bmask_b = 4'($urandom); i_wren_b = 1'($urandom);
        i_lsu_rdata = $urandom;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic ra; logic [31:0] aa; logic wa;
        logic rb; logic [31:0] ab; logic wb;
        logic [31:0] rd;
        logic ega, egb, est, ewr; logic [31:0] eaddr; logic erva, ervb;
    } vec_t;
    vec_t vecs[17];

    function automatic vec_t mk(logic ra, logic [31:0] aa, logic wa, logic rb, logic [31:0] ab,
                                logic wb, logic [31:0] rd, logic ega, logic egb, logic est,
                                logic ewr, logic [31:0] eaddr, logic erva, logic ervb);
        mk = '{ra, aa, wa, rb, ab, wb, rd, ega, egb, est, ewr, eaddr, erva, ervb};
    endfunction

    initial begin
        // A-only read, then contention until forced B write, then interleaved reads.
        vecs[0] = mk(1, 32'h10, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h10, 0, 0);
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 32'hAAAA_0001, 0, 0, 0, 0, 32'h10, 1, 0);
        for (int i = 0; i < 8; i++)
            vecs[2+i] = mk(1, 32'h40 + 4*i, 0, 1, 32'h7800, 1, 32'h100 + i,
                           1, 0, 0, 0, 32'h40 + 4*i, (i != 0), 0);
        vecs[10] = mk(1, 32'h60, 0, 1, 32'h7800, 1, 32'h200, 0, 1, 1, 1, 32'h7800, 1, 0);
        vecs[11] = mk(1, 32'h60, 0, 1, 32'h7800, 1, 32'h201, 1, 0, 0, 0, 32'h60, 0, 0);
        vecs[12] = mk(1, 32'h20, 0, 0, 0, 0, 32'h202, 1, 0, 0, 0, 32'h20, 1, 0);
        vecs[13] = mk(0, 0, 0, 1, 32'h7800, 0, 32'h203, 0, 1, 0, 0, 32'h7800, 1, 0);
        vecs[14] = mk(1, 32'h24, 0, 0, 0, 0, 32'hBBBB_0002, 1, 0, 0, 0, 32'h24, 0, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 32'hCCCC_0003, 0, 0, 0, 0, 32'h24, 1, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 32'h204, 0, 0, 0, 0, 32'h24, 0, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        int gnt_at;
        cyc = 0;
        model_reset();
        obs_gnt_b = 0;

        // Reset held with random inputs: every output must read 0.
        @(negedge i_clk);
        for (int k = 0; k < 4; k++) begin
            randomize_inputs();
            #1 chk_all_zero("rst_hold");
            @(negedge i_clk);
        end
        idle_inputs();
        i_reset = 1'b1;
        for (int k = 0; k < 2; k++) step("rst_release");

        // Directed table (state is fresh: two idle cycles after reset).
        for (int v = 0; v < 17; v++) begin
            i_req_a = vecs[v].ra; i_addr_a = vecs[v].aa; i_wren_a = vecs[v].wa;
            i_wdata_a = 32'hA000_0000 + v; i_bmask_a = 4'hF;
            i_req_b = vecs[v].rb; i_addr_b = vecs[v].ab; i_wren_b = vecs[v].wb;
            i_wdata_b = 32'hB000_0000 + v; i_bmask_b = 4'h3;
            i_lsu_rdata = vecs[v].rd;
            #1;
            chk($sformatf("vec%0d.gnt_a", v), o_gnt_a, vecs[v].ega);
            chk($sformatf("vec%0d.gnt_b", v), o_gnt_b, vecs[v].egb);
            chk($sformatf("vec%0d.stall", v), o_stall_mem, vecs[v].est);
            chk($sformatf("vec%0d.wren", v), o_lsu_wren, vecs[v].ewr);
            chk($sformatf("vec%0d.addr", v), o_lsu_addr, vecs[v].eaddr);
            chk($sformatf("vec%0d.rvalid_a", v), o_rvalid_a, vecs[v].erva);
            chk($sformatf("vec%0d.rvalid_b", v), o_rvalid_b, vecs[v].ervb);
            chk($sformatf("vec%0d.rdata", v), o_rdata, vecs[v].rd);
            @(posedge i_clk);
            @(negedge i_clk);
        end

        // Reset during a read: the in-flight read must never return.
        idle_inputs();
        i_reset = 1'b0;
        model_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        step("pre_rd");
        i_req_a = 1; i_addr_a = 32'h30; i_wren_a = 0; i_lsu_rdata = 32'h1234_5678;
        step("rd_issue");
        idle_inputs();
        i_reset = 1'b0;
        model_reset();
        #1 chk_all_zero("rst_mid_rd");
        @(negedge i_clk);
        i_reset = 1'b1;
        for (int k = 0; k < 3; k++) step("post_rst");

        // B withdraws after 5 refusals, then needs 8 fresh refusals under A traffic.
        i_req_a = 1; i_addr_a = 32'h80; i_wren_a = 0;
        i_req_b = 1; i_addr_b = 32'h7804; i_wren_b = 1; i_wdata_b = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) step("b_wait5");
        i_req_b = 0;
        step("b_drop");
        i_req_b = 1;
        gnt_at = 0;
        for (int k = 1; k <= 12 && gnt_at == 0; k++) begin
            step("b_rereq");
            if (obs_gnt_b) gnt_at = k;
        end
        chk("b_forced_after_fresh_wait", gnt_at, MAX_WAIT + 1);
        step("after_force");

        // B drops exactly in its forced cycle: no grant at all, then A resumes.
        idle_inputs();
        step("idle");
        i_req_a = 1; i_req_b = 1; i_wren_b = 0;
        for (int k = 0; k < MAX_WAIT; k++) step("force_pre");
        i_req_b = 0;
        step("force_drop");
        step("force_after_drop");

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            randomize_inputs();
            if (($urandom % 4) != 0) i_req_a = 1;
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
